mem_port_arbiter: RTL and testbench

//   Shares one single-port unified memory between the fetch stage (IF) and the memory stage (DM).

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DM) requesters; DM has priority with
// a starvation limit. Defining MEM_PORT_ARB_PERF_EN adds the perf_conflicts counter port.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

  state_t            state_q;
  logic              mem_req_q, mem_we_q, if_ready_q, dm_ready_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
  logic [3:0]        streak_q, streak_d;
  logic              if_live, dm_live, grant_dm, grant_if;

  // A requester whose ready pulse is high this cycle is still holding req from the finished access.
  assign if_live = if_req & ~if_ready_q;
  assign dm_live = dm_req & ~dm_ready_q;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    streak_d = streak_q;
    if (state_q == IDLE) begin
      grant_dm = dm_live & (~if_live | (streak_q != STREAK_MAX));
      grant_if = if_live & ~grant_dm;
      if (grant_if) begin
        streak_d = '0;
      end else if (grant_dm) begin
        if (!if_req)                      streak_d = '0;
        else if (streak_q != STREAK_MAX)  streak_d = streak_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      streak_q    <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      streak_q   <= streak_d;
      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            state_q     <= DM_WAIT;
          end else if (grant_if) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            state_q     <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata;
            if_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DM_WAIT: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            if (!mem_we_q) dm_rdata_q <= mem_rdata;
            dm_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;

  assign perf_d = perf_q + 32'((state_q == IDLE) & if_live & dm_live);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_conflicts = perf_q;
`endif

  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign dm_stall  = dm_req & ~dm_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a responder models the memory, expected grants and read
// data are queued when stimulus is driven and compared when the DUT issues/completes accesses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_conflicts;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
`ifdef MEM_PORT_ARB_PERF_EN
    .perf_conflicts(perf_conflicts),
`endif
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } grant_t;

  int          errors = 0;
  int          checks = 0;
  grant_t      grant_q[$];
  logic [31:0] if_data_q[$];
  logic [31:0] dm_data_q[$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_dm_hold = 32'h0;
  int          ack_delay = 1;
  bit          resp_en = 1'b1;
  int          inject_req = 0;
  int          inject_done = 0;
  int          wait_cnt = 0;
  bit          prev_req = 1'b0;
  grant_t      g;
  logic [31:0] d;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) + 32'h0000_1234;
  endfunction

  // Memory responder: acks ack_delay cycles after mem_req is first seen, or on an injected request.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (inject_req != inject_done) begin
        inject_done = inject_req;
        mem_ack     = 1'b1;
        mem_rdata   = 32'h5A5A_0001;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (resp_en && mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = 32'hBADD_F00D;
          end else begin
            mem_rdata = model_read(mem_addr);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Scoreboard monitor: every new mem_req and every ready pulse must match the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got addr=%h we=%b, no grant expected", mem_addr, mem_we);
        end else begin
          g = grant_q.pop_front();
          if (mem_addr !== g.addr || mem_we !== g.we || (g.we && mem_wdata !== g.wdata)) begin
            errors++;
            $display("FAIL grant_order: got addr=%h we=%b wdata=%h, want %s addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, g.is_dm ? "DM" : "IF", g.addr, g.we, g.wdata);
          end
        end
      end
      prev_req = mem_req;
      if (if_ready) begin
        checks++;
        if (if_data_q.size() == 0) begin
          errors++;
          $display("FAIL if_ready_unexpected: got pulse with rdata=%h, want none", if_rdata);
        end else begin
          d = if_data_q.pop_front();
          if (if_rdata !== d) begin
            errors++;
            $display("FAIL if_rdata: got %h, want %h", if_rdata, d);
          end
        end
      end
      if (dm_ready) begin
        checks++;
        if (dm_data_q.size() == 0) begin
          errors++;
          $display("FAIL dm_ready_unexpected: got pulse with rdata=%h, want none", dm_rdata);
        end else begin
          d = dm_data_q.pop_front();
          if (dm_rdata !== d) begin
            errors++;
            $display("FAIL dm_rdata: got %h, want %h", dm_rdata, d);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // One uncontended access; called at a negedge in an idle cycle, returns one cycle after ready.
  task automatic do_access(input bit is_dm, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat);
    int lat = 0;
    bit done = 1'b0;
    grant_q.push_back('{is_dm, addr, we, wdata});
    if (is_dm) begin
      if (!we) exp_dm_hold = model_read(addr);
      dm_data_q.push_back(exp_dm_hold);
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_data_q.push_back(model_read(addr));
      if_req = 1'b1; if_addr = addr;
    end
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      done = is_dm ? dm_ready : if_ready;
    end
    checks++;
    if (!done || lat != exp_lat) begin
      errors++;
      $display("FAIL access_latency: got %0d cycles (done=%b), want %0d", lat, done, exp_lat);
    end
    if (is_dm) dm_req = 1'b0;
    else       if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse_width: got if_ready=%b dm_ready=%b, want 0 0", if_ready, dm_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_ready, dm_ready, if_stall, dm_stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b we=%b ifr=%b dmr=%b ifs=%b dms=%b, want all 0",
               mem_req, mem_we, if_ready, dm_ready, if_stall, dm_stall);
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h dm_rdata=%h, want 0",
               mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_only();
    mem_model[32'h100] = 32'h0050_0093;
    grant_q.push_back('{1'b0, 32'h100, 1'b0, 32'h0});
    if_data_q.push_back(32'h0050_0093);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || if_stall !== 1'b1) begin
      errors++;
      $display("FAIL if_issue: got req=%b addr=%h we=%b stall=%b, want 1 100 0 1",
               mem_req, mem_addr, mem_we, if_stall);
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin
      errors++;
      $display("FAIL if_early_ready: got if_ready=%b at cycle 2, want 0", if_ready);
    end
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h0050_0093 || if_stall !== 1'b0) begin
      errors++;
      $display("FAIL if_complete: got ready=%b rdata=%h stall=%b, want 1 00500093 0",
               if_ready, if_rdata, if_stall);
    end
    // if_req stays high across the ready cycle: it is the consumed request and must not re-grant.
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL if_consumed: got mem_req=%b if_ready=%b, want 0 0", mem_req, if_ready);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dm_store();
    int lat = 0;
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 3);
    grant_q.push_back('{1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF});
    dm_data_q.push_back(exp_dm_hold);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || dm_stall !== 1'b1) begin
      errors++;
      $display("FAIL dm_store_issue: got req=%b we=%b wdata=%h stall=%b, want 1 1 deadbeef 1",
               mem_req, mem_we, mem_wdata, dm_stall);
    end
    while (dm_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== model_read(32'h80)) begin
      errors++;
      $display("FAIL dm_store_hold: got ready=%b rdata=%h, want 1 %h", dm_ready, dm_rdata,
               model_read(32'h80));
    end
    dm_req = 1'b0;
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 3);
    checks++;
    if (dm_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dm_load_back: got %h, want deadbeef", dm_rdata);
    end
  endtask

  task automatic test_wait_states();
    ack_delay = 5;
    grant_q.push_back('{1'b1, 32'h60, 1'b1, 32'hCAFE_F00D});
    dm_data_q.push_back(exp_dm_hold);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h60; dm_wdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h60 || mem_wdata !== 32'hCAFE_F00D ||
          mem_we !== 1'b1 || dm_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold_c%0d: got req=%b addr=%h wdata=%h we=%b ready=%b, want 1 60 cafef00d 1 0",
                 c, mem_req, mem_addr, mem_wdata, mem_we, dm_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (dm_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: got dm_ready=%b at cycle 7, want 1", dm_ready);
    end
    dm_req = 1'b0;
    ack_delay = 1;
    @(negedge clk);
    do_access(1'b0, 1'b0, 32'h60, 32'h0, 3);
  endtask

  task automatic test_spurious_ack();
    inject_req++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0 || dm_ready !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL spurious_ack: got if_ready=%b dm_ready=%b mem_req=%b, want 0 0 0",
                 if_ready, dm_ready, mem_req);
      end
    end
    do_access(1'b0, 1'b0, 32'h104, 32'h0, 3);
  endtask

  // Both held: the finishing side is ignored in its ready cycle, so the other side gets the port.
  task automatic test_back_to_back();
    int  cyc = 0;
    int  dm_cnt = 0;
    int  if_at = 0;
    grant_q.push_back('{1'b1, 32'h300, 1'b0, 32'h0});
    grant_q.push_back('{1'b0, 32'h200, 1'b0, 32'h0});
    grant_q.push_back('{1'b1, 32'h300, 1'b0, 32'h0});
    exp_dm_hold = model_read(32'h300);
    dm_data_q.push_back(exp_dm_hold);
    dm_data_q.push_back(exp_dm_hold);
    if_data_q.push_back(model_read(32'h200));
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h200;
    while (dm_cnt < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_ready) begin
        if_at = cyc;
        if_req = 1'b0;
      end
      if (dm_ready) begin
        dm_cnt++;
        if (dm_cnt == 1) begin
          checks++;
          if (if_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_if_stall: got if_stall=%b while DM completes, want 1", if_stall);
          end
        end
      end
    end
    dm_req = 1'b0;
    checks++;
    if (cyc != 9 || if_at != 6) begin
      errors++;
      $display("FAIL b2b_timing: got last dm_ready at %0d, if_ready at %0d, want 9 and 6", cyc, if_at);
    end
    @(negedge clk);
  endtask

  // IF drops only during DM ready cycles, so DM wins consecutively until the streak limit.
  task automatic test_starvation();
    int cyc = 0;
    int dm_cnt = 0;
    int dm_at_if = -1;
    bit if_done = 1'b0;
    for (int i = 0; i < 4; i++) grant_q.push_back('{1'b1, 32'h310, 1'b0, 32'h0});
    grant_q.push_back('{1'b0, 32'h210, 1'b0, 32'h0});
    grant_q.push_back('{1'b1, 32'h310, 1'b0, 32'h0});
    exp_dm_hold = model_read(32'h310);
    for (int i = 0; i < 5; i++) dm_data_q.push_back(exp_dm_hold);
    if_data_q.push_back(model_read(32'h210));
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h310;
    if_req = 1'b1; if_addr = 32'h210;
    while (dm_cnt < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (if_ready) begin
        if_done = 1'b1;
        dm_at_if = dm_cnt;
        if_req = 1'b0;
      end else if (!if_done) begin
        if_req = !dm_ready;
      end
      if (dm_ready) dm_cnt++;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    checks++;
    if (!if_done || dm_at_if != 4 || dm_cnt != 5) begin
      errors++;
      $display("FAIL starvation: got if_done=%b after %0d DM accesses (total %0d), want IF after 4 of 5",
               if_done, dm_at_if, dm_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cyc = 0;
    resp_en = 1'b0;
    grant_q.push_back('{1'b1, 32'h70, 1'b1, 32'h1111_2222});
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h70; dm_wdata = 32'h1111_2222;
    while (mem_req !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || dm_stall !== 1'b1) begin
      errors++;
      $display("FAIL abort_immediate: got req=%b we=%b addr=%h dm_stall=%b, want 0 0 0 1",
               mem_req, mem_we, mem_addr, dm_stall);
    end
    dm_req = 1'b0;
    exp_dm_hold = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inject_req++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (dm_ready !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL abort_late_ack: got dm_ready=%b mem_req=%b, want 0 0", dm_ready, mem_req);
      end
    end
    resp_en = 1'b1;
    do_access(1'b1, 1'b0, 32'h70, 32'h0, 3);
    checks++;
    if (dm_rdata !== model_read(32'h70) || mem_model.exists(32'h70)) begin
      errors++;
      $display("FAIL abort_clean: got dm_rdata=%h written=%b, want %h 0", dm_rdata,
               mem_model.exists(32'h70), model_read(32'h70));
    end
  endtask

`ifdef MEM_PORT_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dm_hold = 32'h0;
    @(negedge clk);
    checks++;
    if (perf_conflicts !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d, want 0", perf_conflicts);
    end
    test_starvation();
    test_starvation();
    checks++;
    if (perf_conflicts !== 32'd10) begin
      errors++;
      $display("FAIL perf_count: got %0d, want 10", perf_conflicts);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (perf_conflicts !== 32'd0) begin
      errors++;
      $display("FAIL perf_clear: got %0d, want 0", perf_conflicts);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_if_only();
    test_dm_store();
    test_wait_states();
    test_spurious_ack();
    test_back_to_back();
    test_starvation();
    test_reset_abort();
`ifdef MEM_PORT_ARB_PERF_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (grant_q.size() != 0 || if_data_q.size() != 0 || dm_data_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d grants, %0d IF, %0d DM pending, want 0 0 0",
               grant_q.size(), if_data_q.size(), dm_data_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
